// File: rtl/debug_unit.sv
// debug_unit: UART byte-stream debug controller for the MIPS pipeline (load, step/run, state report).
// Define DEBUG_UNIT_CYCLE_COUNT_EN to append a 32-bit stepped-cycle counter to every report.
module debug_unit #(
    parameter int NB              = 32,
    parameter int NB_BYTE         = 8,
    parameter int NB_REG_SEL      = 5,
    parameter int NB_INSTR_ADDR   = 8,
    parameter int TAM_DATA_MEMORY = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NB_BYTE-1:0]       i_rx_data,
    input  logic                     i_rx_valid,
    input  logic                     i_tx_ready,
    output logic [NB_BYTE-1:0]       o_tx_data,
    output logic                     o_tx_valid,
    input  logic [NB-1:0]            i_mips_pc,
    input  logic [NB-1:0]            i_mips_register_data,
    input  logic [NB-1:0]            i_mips_data_memory,
    input  logic                     i_mips_halt,
    output logic                     o_step,
    output logic [NB_REG_SEL-1:0]    o_debug_mips_register_number,
    output logic [NB-1:0]            o_debug_address,
    output logic                     o_pipeline_reset,
    output logic                     o_instr_wr_en,
    output logic [NB_INSTR_ADDR-1:0] o_instr_wr_addr,
    output logic [NB-1:0]            o_instr_wr_data
);
    localparam int N_GPR = 1 << NB_REG_SEL;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
    localparam int N_WORDS = 1 + N_GPR + TAM_DATA_MEMORY + 1;
`else
    localparam int N_WORDS = 1 + N_GPR + TAM_DATA_MEMORY;
`endif
    localparam int NB_SEL = $clog2(N_WORDS + 1);
    localparam logic [NB_SEL-1:0] FIRST_MEM = NB_SEL'(1 + N_GPR);
    localparam logic [NB_SEL-1:0] END_MEM   = NB_SEL'(1 + N_GPR + TAM_DATA_MEMORY);
    localparam logic [NB_SEL-1:0] LAST_WORD = NB_SEL'(N_WORDS - 1);

    localparam logic [NB_BYTE-1:0] CMD_LOAD   = NB_BYTE'(8'h4C);
    localparam logic [NB_BYTE-1:0] CMD_STEP   = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0] CMD_RUN    = NB_BYTE'(8'h43);
    localparam logic [NB_BYTE-1:0] CMD_REPORT = NB_BYTE'(8'h52);

    typedef enum logic [3:0] {
        IDLE, LOAD_COUNT, LOAD_BYTES, LOAD_WRITE, STEP, RUN,
        REPORT_SETUP, REPORT_LATCH, REPORT_SEND
    } state_t;

    state_t                   r_state, w_state_next;
    logic [NB_BYTE-1:0]       r_tx_data, w_tx_data_next;
    logic                     r_tx_valid, w_tx_valid_next;
    logic                     r_step, w_step_next;
    logic [NB_REG_SEL-1:0]    r_reg_num, w_reg_num_next;
    logic [NB-1:0]            r_debug_address, w_debug_address_next;
    logic                     r_pipeline_reset, w_pipeline_reset_next;
    logic                     r_instr_wr_en, w_instr_wr_en_next;
    logic [NB_INSTR_ADDR-1:0] r_instr_wr_addr, w_instr_wr_addr_next;
    logic [NB-1:0]            r_instr_wr_data, w_instr_wr_data_next;
    logic [NB_BYTE-1:0]       r_words_left, w_words_left_next;
    logic [1:0]               r_byte_cnt, w_byte_cnt_next;
    logic [NB-1:0]            r_shift, w_shift_next;
    logic [NB_SEL-1:0]        r_word_sel, w_word_sel_next;
    logic                     r_latch_wait, w_latch_wait_next;
    logic [NB-1:0]            w_capture;
    logic [NB_SEL-1:0]        w_mem_idx;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
    logic [31:0]              r_cycle_cnt;
    logic                     w_clear_cnt;
`endif

    assign w_mem_idx = r_word_sel - FIRST_MEM;

    // Report word order: PC, GPR0..GPR31, data words, then (optionally) the cycle counter.
    always_comb begin
        w_capture = i_mips_data_memory;
        if (r_word_sel == '0)
            w_capture = i_mips_pc;
        else if (r_word_sel < FIRST_MEM)
            w_capture = i_mips_register_data;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
        else if (r_word_sel >= END_MEM)
            w_capture = NB'(r_cycle_cnt);
`endif
    end

    always_comb begin
        w_state_next          = r_state;
        w_tx_data_next        = r_tx_data;
        w_tx_valid_next       = r_tx_valid;
        w_step_next           = r_step;
        w_reg_num_next        = r_reg_num;
        w_debug_address_next  = r_debug_address;
        w_pipeline_reset_next = r_pipeline_reset;
        w_instr_wr_en_next    = 1'b0;
        w_instr_wr_addr_next  = r_instr_wr_addr;
        w_instr_wr_data_next  = r_instr_wr_data;
        w_words_left_next     = r_words_left;
        w_byte_cnt_next       = r_byte_cnt;
        w_shift_next          = r_shift;
        w_word_sel_next       = r_word_sel;
        w_latch_wait_next     = r_latch_wait;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
        w_clear_cnt           = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (i_rx_valid) begin
                    case (i_rx_data)
                        CMD_LOAD: begin
                            w_state_next          = LOAD_COUNT;
                            w_pipeline_reset_next = 1'b1;
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
                            w_clear_cnt           = 1'b1;
`endif
                        end
                        CMD_STEP, CMD_RUN: begin
                            w_state_next = (i_rx_data == CMD_STEP) ? STEP : RUN;
                            w_step_next  = 1'b1;
                        end
                        CMD_REPORT: begin
                            w_state_next    = REPORT_SETUP;
                            w_word_sel_next = '0;
                        end
                        default: ;
                    endcase
                end
            end
            LOAD_COUNT: begin
                if (i_rx_valid) begin
                    if (i_rx_data == '0) begin
                        w_state_next          = IDLE;
                        w_pipeline_reset_next = 1'b0;
                    end else begin
                        w_state_next         = LOAD_BYTES;
                        w_words_left_next    = i_rx_data;
                        w_instr_wr_addr_next = '0;
                        w_byte_cnt_next      = '0;
                    end
                end
            end
            LOAD_BYTES: begin
                if (i_rx_valid) begin
                    w_shift_next    = {r_shift[NB-NB_BYTE-1:0], i_rx_data};
                    w_byte_cnt_next = r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) begin
                        w_state_next         = LOAD_WRITE;
                        w_instr_wr_en_next   = 1'b1;
                        w_instr_wr_data_next = {r_shift[NB-NB_BYTE-1:0], i_rx_data};
                    end
                end
            end
            LOAD_WRITE: begin
                w_words_left_next = r_words_left - NB_BYTE'(1);
                if (r_words_left == NB_BYTE'(1)) begin
                    w_state_next          = IDLE;
                    w_pipeline_reset_next = 1'b0;
                end else begin
                    w_state_next         = LOAD_BYTES;
                    w_instr_wr_addr_next = r_instr_wr_addr + NB_INSTR_ADDR'(1);
                end
            end
            STEP: begin
                w_step_next     = 1'b0;
                w_word_sel_next = '0;
                w_state_next    = REPORT_SETUP;
            end
            RUN: begin
                if (i_mips_halt) begin
                    w_step_next     = 1'b0;
                    w_word_sel_next = '0;
                    w_state_next    = REPORT_SETUP;
                end
            end
            REPORT_SETUP: begin
                if (r_word_sel != '0 && r_word_sel < FIRST_MEM)
                    w_reg_num_next = NB_REG_SEL'(r_word_sel - NB_SEL'(1));
                else if (r_word_sel >= FIRST_MEM && r_word_sel < END_MEM)
                    w_debug_address_next = NB'(w_mem_idx) << 2;
                w_latch_wait_next = 1'b0;
                w_state_next      = REPORT_LATCH;
            end
            REPORT_LATCH: begin
                // Select has been stable a full cycle before the word is captured.
                if (!r_latch_wait) begin
                    w_latch_wait_next = 1'b1;
                end else begin
                    w_tx_data_next  = w_capture[NB-1 -: NB_BYTE];
                    w_shift_next    = {w_capture[NB-NB_BYTE-1:0], NB_BYTE'(0)};
                    w_tx_valid_next = 1'b1;
                    w_byte_cnt_next = '0;
                    w_state_next    = REPORT_SEND;
                end
            end
            REPORT_SEND: begin
                if (r_tx_valid && i_tx_ready) begin
                    if (r_byte_cnt == 2'd3) begin
                        w_tx_valid_next = 1'b0;
                        if (r_word_sel == LAST_WORD) begin
                            w_state_next = IDLE;
                        end else begin
                            w_word_sel_next = r_word_sel + NB_SEL'(1);
                            w_state_next    = REPORT_SETUP;
                        end
                    end else begin
                        w_tx_data_next  = r_shift[NB-1 -: NB_BYTE];
                        w_shift_next    = {r_shift[NB-NB_BYTE-1:0], NB_BYTE'(0)};
                        w_byte_cnt_next = r_byte_cnt + 2'd1;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state          <= IDLE;
            r_tx_data        <= '0;
            r_tx_valid       <= 1'b0;
            r_step           <= 1'b0;
            r_reg_num        <= '0;
            r_debug_address  <= '0;
            r_pipeline_reset <= 1'b0;
            r_instr_wr_en    <= 1'b0;
            r_instr_wr_addr  <= '0;
            r_instr_wr_data  <= '0;
            r_words_left     <= '0;
            r_byte_cnt       <= '0;
            r_shift          <= '0;
            r_word_sel       <= '0;
            r_latch_wait     <= 1'b0;
        end else begin
            r_state          <= w_state_next;
            r_tx_data        <= w_tx_data_next;
            r_tx_valid       <= w_tx_valid_next;
            r_step           <= w_step_next;
            r_reg_num        <= w_reg_num_next;
            r_debug_address  <= w_debug_address_next;
            r_pipeline_reset <= w_pipeline_reset_next;
            r_instr_wr_en    <= w_instr_wr_en_next;
            r_instr_wr_addr  <= w_instr_wr_addr_next;
            r_instr_wr_data  <= w_instr_wr_data_next;
            r_words_left     <= w_words_left_next;
            r_byte_cnt       <= w_byte_cnt_next;
            r_shift          <= w_shift_next;
            r_word_sel       <= w_word_sel_next;
            r_latch_wait     <= w_latch_wait_next;
        end
    end

`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_cycle_cnt <= '0;
        else if (w_clear_cnt)
            r_cycle_cnt <= '0;
        else if (r_step)
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end
`endif

    assign o_tx_data                    = r_tx_data;
    assign o_tx_valid                   = r_tx_valid;
    assign o_step                       = r_step;
    assign o_debug_mips_register_number = r_reg_num;
    assign o_debug_address              = r_debug_address;
    assign o_pipeline_reset             = r_pipeline_reset;
    assign o_instr_wr_en                = r_instr_wr_en;
    assign o_instr_wr_addr              = r_instr_wr_addr;
    assign o_instr_wr_data              = r_instr_wr_data;

endmodule

// File: tb/tb_debug_unit.sv
// Self-checking bench for debug_unit: load/command tables, report-byte scoreboard, tx stalls, async reset.
module tb_debug_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        tx_ready = 1'b1;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [31:0] pc = '0;
    logic [31:0] reg_data;
    logic [31:0] mem_data;
    logic        halt = 1'b0;
    logic        step;
    logic [4:0]  reg_num;
    logic [31:0] dbg_addr;
    logic        prst;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;

    always #5 clk = ~clk;

`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
    localparam int REPORT_BYTES = 200;
`else
    localparam int REPORT_BYTES = 196;
`endif
    localparam logic [7:0] CMD_L = 8'h4C;
    localparam logic [7:0] CMD_S = 8'h53;
    localparam logic [7:0] CMD_C = 8'h43;
    localparam logic [7:0] CMD_R = 8'h52;

    function automatic logic [31:0] gpr_val(input logic [4:0] n);
        return {8'hC0, 3'b000, n, 8'h5A, 3'b111, ~n};
    endfunction

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return 32'hD00D_0000 | (a * 32'h0000_0101);
    endfunction

    assign reg_data = gpr_val(reg_num);
    assign mem_data = mem_val(dbg_addr);

    debug_unit dut (
        .i_clk                        (clk),
        .i_reset                      (rst),
        .i_rx_data                    (rx_data),
        .i_rx_valid                   (rx_valid),
        .i_tx_ready                   (tx_ready),
        .o_tx_data                    (tx_data),
        .o_tx_valid                   (tx_valid),
        .i_mips_pc                    (pc),
        .i_mips_register_data         (reg_data),
        .i_mips_data_memory           (mem_data),
        .i_mips_halt                  (halt),
        .o_step                       (step),
        .o_debug_mips_register_number (reg_num),
        .o_debug_address              (dbg_addr),
        .o_pipeline_reset             (prst),
        .o_instr_wr_en                (wr_en),
        .o_instr_wr_addr              (wr_addr),
        .o_instr_wr_data              (wr_data)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  exp_q[$];
    logic [39:0] wr_q[$];
    int          rep_bytes   = 0;
    int          step_cycles = 0;
    int          stall_at    = -1;
    int          stall_left  = 0;
    logic [31:0] model_cnt   = '0;

    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b1;
    logic [7:0] prev_data  = '0;
    logic       prev_wr    = 1'b0;
    logic [7:0] exp_b;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Output monitor: owns tx_ready, pops the scoreboard on each handshake, tracks step/write pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_valid && !prev_ready) begin
                chk("tx_hold_valid", {63'd0, tx_valid}, 64'd1);
                chk("tx_hold_data", {56'd0, tx_data}, {56'd0, prev_data});
            end
            if (stall_left > 0) begin
                tx_ready = 1'b0;
                stall_left--;
            end else if (stall_at >= 0 && rep_bytes == stall_at && tx_valid) begin
                tx_ready   = 1'b0;
                stall_left = 4;
                stall_at   = -1;
            end else begin
                tx_ready = 1'b1;
            end
            if (tx_valid && tx_ready) begin
                rep_bytes++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL tx_extra: got byte 0x%h, expected no byte", tx_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    chk("tx_byte", {56'd0, tx_data}, {56'd0, exp_b});
                end
            end
            if (step) step_cycles++;
            if (wr_en) begin
                chk("wr_en_width", {63'd0, prev_wr}, 64'd0);
                chk("wr_prst_high", {63'd0, prst}, 64'd1);
                wr_q.push_back({wr_addr, wr_data});
            end
            prev_wr    = wr_en;
            prev_valid = tx_valid;
            prev_ready = tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_valid = 1'b0;
            prev_wr    = 1'b0;
        end
    end

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    endtask

    task automatic push_report(input logic [31:0] pc_v);
        push_word(pc_v);
        for (int r = 0; r < 32; r++) push_word(gpr_val(5'(r)));
        for (int k = 0; k < 16; k++) push_word(mem_val(32'(4 * k)));
`ifdef DEBUG_UNIT_CYCLE_COUNT_EN
        push_word(model_cnt);
`endif
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_report(input int exp_n);
        int t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("report_drained", 64'(exp_q.size()), 64'd0);
        chk("report_bytes", 64'(rep_bytes), 64'(exp_n));
        chk("report_tx_idle", {63'd0, tx_valid}, 64'd0);
    endtask

    typedef struct {
        int              n;
        logic [2:0][31:0] words;
    } load_vec_t;

    typedef struct {
        logic [7:0]  cmd;
        logic [31:0] pc;
        int          halt_delay;
        int          exp_steps;
        int          stall_at;
    } cmd_vec_t;

    load_vec_t   lv[3];
    cmd_vec_t    cv[4];
    logic [31:0] word;

    initial begin
        lv[0] = '{2, {32'h0000_0000, 32'h30E3_000F, 32'h2027_0003}};
        lv[1] = '{3, {32'h8000_0001, 32'h0123_4567, 32'hDEAD_BEEF}};
        lv[2] = '{0, {32'h0, 32'h0, 32'h0}};
        cv[0] = '{CMD_R, 32'h0000_0100, 0, 0, -1};
        cv[1] = '{CMD_C, 32'h0000_0040, 10, 10, 77};
        cv[2] = '{CMD_S, 32'h0000_000C, 0, 1, 2};
        cv[3] = '{CMD_C, 32'h0000_0044, 0, 1, -1};

        repeat (2) @(negedge clk);
        chk("rst_ctrl", {39'd0, tx_data, tx_valid, step, reg_num, prst, wr_en, wr_addr}, 64'd0);
        chk("rst_addr", {32'd0, dbg_addr}, 64'd0);
        chk("rst_wdata", {32'd0, wr_data}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 3; v++) begin
            wr_q.delete();
            send_byte(CMD_L);
            chk("load_prst_rise", {63'd0, prst}, 64'd1);
            model_cnt = '0;
            repeat (2) @(negedge clk);
            send_byte(8'(lv[v].n));
            repeat (2) @(negedge clk);
            for (int w = 0; w < lv[v].n; w++) begin
                word = lv[v].words[w];
                for (int b = 3; b >= 0; b--) begin
                    send_byte(word[8*b +: 8]);
                    if (b == 0) chk("load_prst_hold", {63'd0, prst}, 64'd1);
                    repeat (2) @(negedge clk);
                end
            end
            chk("load_prst_fall", {63'd0, prst}, 64'd0);
            chk("load_wr_count", 64'(wr_q.size()), 64'(lv[v].n));
            for (int i = 0; i < wr_q.size() && i < lv[v].n; i++)
                chk("load_wr", {24'd0, wr_q[i]}, {24'd0, 8'(i), lv[v].words[i]});
            $display("[TB] load N=%0d words, %0d writes seen", lv[v].n, wr_q.size());
        end

        for (int i = 0; i < 4; i++) begin
            pc          = cv[i].pc;
            step_cycles = 0;
            rep_bytes   = 0;
            stall_at    = cv[i].stall_at;
            model_cnt   = model_cnt + 32'(cv[i].exp_steps);
            push_report(pc);
            if (cv[i].cmd == CMD_C && cv[i].halt_delay == 0) halt = 1'b1;
            send_byte(cv[i].cmd);
            if (cv[i].cmd == CMD_C && cv[i].halt_delay > 0) begin
                repeat (cv[i].halt_delay - 1) @(negedge clk);
                halt = 1'b1;
            end
            wait_report(REPORT_BYTES);
            halt = 1'b0;
            chk("step_cycles", 64'(step_cycles), 64'(cv[i].exp_steps));
            $display("[TB] cmd '%c' pc=0x%h step_cycles=%0d report_bytes=%0d", cv[i].cmd, cv[i].pc,
                     step_cycles, rep_bytes);
        end

        step_cycles = 0;
        send_byte(8'h58);
        repeat (5) @(negedge clk);
        chk("ignored_tx", {63'd0, tx_valid}, 64'd0);
        chk("ignored_step", 64'(step_cycles), 64'd0);
        chk("ignored_prst", {63'd0, prst}, 64'd0);
        $display("[TB] unknown byte 0x58 ignored");

        pc        = 32'h0000_0200;
        rep_bytes = 0;
        wr_q.delete();
        push_report(pc);
        send_byte(CMD_R);
        repeat (20) @(negedge clk);
        send_byte(CMD_S);
        repeat (3) @(negedge clk);
        send_byte(CMD_L);
        wait_report(REPORT_BYTES);
        chk("drop_step", 64'(step_cycles), 64'd0);
        chk("drop_prst", {63'd0, prst}, 64'd0);
        $display("[TB] bytes during report dropped, report_bytes=%0d", rep_bytes);

        send_byte(CMD_L);
        repeat (2) @(negedge clk);
        send_byte(8'h02);
        repeat (2) @(negedge clk);
        send_byte(8'h11);
        repeat (2) @(negedge clk);
        send_byte(8'h22);
        repeat (2) @(negedge clk);
        send_byte(8'h33);
        chk("pre_reset_prst", {63'd0, prst}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ctrl", {39'd0, tx_data, tx_valid, step, reg_num, prst, wr_en, wr_addr}, 64'd0);
        chk("arst_addr", {32'd0, dbg_addr}, 64'd0);
        chk("arst_wdata", {32'd0, wr_data}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_cnt = '0;
        pc        = 32'h0000_0300;
        rep_bytes = 0;
        push_report(pc);
        send_byte(CMD_R);
        wait_report(REPORT_BYTES);
        chk("reset_no_writes", 64'(wr_q.size()), 64'd0);
        $display("[TB] async reset mid-load, then report_bytes=%0d", rep_bytes);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 1 ms");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/debug_unit.md
Name: debug_unit

Overview:
Host-side debug controller that sits directly upstream of the MIPS pipeline. It drives the pipeline's step enable, debug register select and debug memory address, and it consumes the pipeline's PC, register, and data-memory outputs. It parses a byte-stream command protocol from a UART receiver, loads instruction memory, runs the core in step or continuous mode, and streams a state report to a UART transmitter.

Parameters:
NB, 32, data/PC word width
NB_BYTE, 8, UART byte width
NB_REG_SEL, 5, register-number width (32 GPRs)
NB_INSTR_ADDR, 8, instruction-memory word-address width
TAM_DATA_MEMORY, 16, number of data-memory words dumped in a report

Ports:
i_clk  in  1  clock
i_reset  in  1  reset, asynchronous active-high
i_rx_data  in  NB_BYTE  received byte
i_rx_valid  in  1  one-cycle pulse, i_rx_data valid
i_tx_ready  in  1  transmitter can accept a byte
o_tx_data  out  NB_BYTE  byte to transmit
o_tx_valid  out  1  o_tx_data valid
i_mips_pc  in  NB  pipeline PC
i_mips_register_data  in  NB  GPR selected by o_debug_mips_register_number
i_mips_data_memory  in  NB  data word at o_debug_address
i_mips_halt  in  1  HALT has reached write-back
o_step  out  1  pipeline advance enable
o_debug_mips_register_number  out  NB_REG_SEL  GPR select
o_debug_address  out  NB  data-memory word address (byte address, multiple of 4)
o_pipeline_reset  out  1  holds the pipeline in reset while loading
o_instr_wr_en  out  1  instruction-memory write strobe
o_instr_wr_addr  out  NB_INSTR_ADDR  instruction word address
o_instr_wr_data  out  NB  instruction word

Behaviour:
- One clock (i_clk). Reset is asynchronous and active-high (i_reset). It forces every output to 0 and the FSM to IDLE immediately. Reset mid-operation abandons the command. No partial report is resumed.
- All outputs are registered.
- Commands are accepted only in IDLE:
  - 'L' (0x4C) load.
  - 'S' (0x53) single step.
  - 'C' (0x43) continuous run.
  - 'R' (0x52) report only.
  - Any other byte is ignored.
- Bytes arriving in RUN, STEP, or REPORT_* are dropped.
- States: IDLE, LOAD_COUNT, LOAD_BYTES, LOAD_WRITE, STEP, RUN, REPORT_SETUP, REPORT_LATCH, REPORT_SEND.
- Load sequence:
  - 'L' goes to LOAD_COUNT; o_pipeline_reset rises on the next edge.
  - The next byte is N (0..255). N=0 returns to IDLE with o_pipeline_reset low and no writes.
  - Otherwise, in LOAD_BYTES, 4 bytes per word are assembled MSB first.
  - After the 4th byte, LOAD_WRITE asserts o_instr_wr_en for exactly 1 cycle with addr = word index (starting at 0).
  - After word N-1 the FSM returns to IDLE and o_pipeline_reset falls in that same transition. The word index wraps modulo 2^NB_INSTR_ADDR.
- STEP: o_step is high for exactly 1 cycle, starting the cycle after 'S' is sampled. Then REPORT_SETUP.
- RUN:
  - o_step goes high the cycle after 'C' is sampled.
  - It stays high until i_mips_halt is sampled high; o_step falls at that same edge. Then REPORT_SETUP.
  - If i_mips_halt is already high on entry, o_step is high for 1 cycle.
- Report, all words big-endian:
  - Sent in order: PC (4 bytes), GPR0..GPR31 (128 bytes), data words 0..TAM_DATA_MEMORY-1 (64 bytes). Total 196 bytes by default.
  - Per word: REPORT_SETUP drives the select (register number, or address = 4·k). REPORT_LATCH waits 1 cycle for read settle, then captures the input into a shift register. REPORT_SEND emits 4 bytes.
- Tx handshake:
  - A byte transfers on an edge where o_tx_valid && i_tx_ready.
  - While o_tx_valid is high and i_tx_ready is low, o_tx_data is held stable.
  - o_tx_valid may rise independent of i_tx_ready.
  - After the last byte transfers, o_tx_valid drops and the FSM enters IDLE.

Optional Feature:
DEBUG_UNIT_CYCLE_COUNT_EN:
- Defined: a 32-bit counter increments on every cycle o_step is high. It clears on 'L' acceptance and wraps at 2^32. Its value is appended as 4 big-endian bytes after the data-memory dump, giving a 200-byte report.
- Undefined: no counter is present and the report is 196 bytes.

Test Plan:
- Load two words: 'L',0x02,0x20,0x27,0x00,0x03,0x30,0xE3,0x00,0x0F → two 1-cycle o_instr_wr_en pulses: addr 0 data 0x20270003, then addr 1 data 0x30E3000F. o_pipeline_reset is high from after 'L' until the final write, and 0 afterwards.
- 'L',0x00 → no o_instr_wr_en pulse and o_pipeline_reset returns low. A following 'R' produces a full 196-byte report.
- 'S' with i_mips_pc=12 → o_step high exactly 1 cycle. The first 4 bytes are 0x00,0x00,0x00,0x0C. o_debug_mips_register_number sweeps 0..31 in order. o_debug_address sweeps 0,4,…,60.
- 'C', i_mips_halt raised 10 cycles after o_step rises → o_step high exactly 10 cycles. With DEBUG_UNIT_CYCLE_COUNT_EN, the last 4 bytes are 0x0000000A.
- i_tx_ready low for 5 cycles mid-report → o_tx_data and o_tx_valid are stable throughout, with no byte lost or duplicated; exactly 196 bytes total.
- i_reset pulsed after 3 load bytes → all outputs 0 immediately. The next 'R' is parsed as a command and reports normally.
